// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the round-robin FIFO read scheduler.
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_SERVE
    } arb_state_t;

    // Channel index width; a single channel still needs a one-bit index.
    function automatic int chan_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after last+1,
// wrapping around, found by rotating a doubled copy of the request vector.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_CH = 4,
    localparam int CW     = chan_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CW-1:0]     last,
    output logic [CW-1:0]     gnt_idx,
    output logic              gnt_any
);

    logic [2*NUM_CH-1:0] req_dbl;
    logic [NUM_CH-1:0]   req_rot;

    always_comb begin
        int start;
        int pos;
        // NOTE: every output of a combinational block gets a default before
        // any conditional assignment, otherwise a latch is inferred.
        gnt_any = 1'b0;
        gnt_idx = '0;
        pos     = 0;
        start   = int'(last) + 1;
        req_dbl = {req, req};
        req_rot = NUM_CH'(req_dbl >> start);
        for (int i = 0; i < NUM_CH; i++) begin
            if (!gnt_any && req_rot[i]) begin
                gnt_any = 1'b1;
                pos     = start + i;
                if (pos >= NUM_CH) begin
                    pos = pos - NUM_CH;
                end
                gnt_idx = CW'(pos);
            end
        end
    end

endmodule

// File: rtl/fifo_rr_arb.sv
// Round-robin read scheduler: shares one valid/ready stream among NUM_CH
// FWFT FIFOs, granting one channel for up to BURST words before rotating.
module fifo_rr_arb
    import fifo_arb_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 32,
    parameter int BURST  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CH-1:0]           ch_empty,
    input  logic [NUM_CH*WIDTH-1:0]     ch_dout,
    output logic [NUM_CH-1:0]           ch_rd,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [WIDTH-1:0]            m_data,
    output logic [chan_w(NUM_CH)-1:0]   m_chan,
    output logic                        m_last,
    output logic                        busy
);

    localparam int                CW       = chan_w(NUM_CH);
    localparam int                CNT_W    = $clog2(BURST + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BURST - 1);
    localparam logic [CW-1:0]     LAST_RST = CW'(NUM_CH - 1);

    arb_state_t        state_q, state_d;
    logic [CW-1:0]     grant_q, grant_d;
    logic [CW-1:0]     last_q,  last_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;

    logic [NUM_CH-1:0] ch_req;
    logic [CW-1:0]     pick_idx;
    logic              pick_any;
    logic              serving;
    logic              sel_empty;
    logic [WIDTH-1:0]  sel_data;
    logic              xfer;

    assign ch_req = ~ch_empty;

    rr_pick #(
        .NUM_CH (NUM_CH)
    ) u_pick (
        .req     (ch_req),
        .last    (last_q),
        .gnt_idx (pick_idx),
        .gnt_any (pick_any)
    );

    // Granted channel's view; held stable by the FIFO itself while not read.
    always_comb begin
        sel_empty = 1'b1;
        sel_data  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_q == CW'(i)) begin
                sel_empty = ch_empty[i];
                sel_data  = ch_dout[i*WIDTH +: WIDTH];
            end
        end
    end

    // Gating with rst keeps the consumer and the FIFO in step during reset.
    always_comb begin
        serving = (state_q == ARB_SERVE);
        m_valid = serving & ~sel_empty & ~rst;
        xfer    = m_valid & m_ready;
        m_data  = serving ? sel_data : '0;
        m_chan  = serving ? grant_q : '0;
        m_last  = m_valid & (cnt_q == CNT_LAST);
        busy    = serving;
        ch_rd   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_rd[i] = xfer & (grant_q == CW'(i));
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    state_d = ARB_SERVE;
                    grant_d = pick_idx;
                    last_d  = pick_idx;
                    cnt_d   = '0;
                end
            end
            ARB_SERVE: begin
                if (xfer) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = ARB_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (sel_empty) begin
                    state_d = ARB_IDLE;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples its _d value from before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            last_q  <= LAST_RST;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
